multicycle_control: RTL and testbench

- Parametrised multi-cycle control unit for the project CPU. It replaces single-cycle opcode decoding with an FSM that sequences fetch, decode, execute, memory and writeback.
- Drives datapath enables and ALU control. Talks to a shared instruction/data memory through a req/ack handshake with a timeout guard.
- Sits between the instruction register and the datapath/memory arbiter.

---
 rtl/multicycle_control_if.sv | 10 +
 rtl/multicycle_control.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Memory request/acknowledge bus between the multi-cycle controller and the
// shared instruction/data memory arbiter.
interface multicycle_control_if;
  logic mem_req;
  logic memwrite;
  logic mem_ack;

  modport master (output mem_req, output memwrite, input mem_ack);
  modport slave  (input mem_req, input memwrite, output mem_ack);
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle CPU control FSM: FETCH/DECODE/EXECUTE/MEM/WB with a memory timeout guard.
// Optional performance counters (retired_cnt, stall_cnt) are built when MCTRL_PERF_EN is defined.
module multicycle_control #(
  parameter int OPCODE_W = 4,
  parameter int ALUCTL_W = 3,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  multicycle_control_if.master mem,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                alusrc,
  output logic [ALUCTL_W-1:0] alucontrol,
  output logic                memtoreg,
  output logic                regwrite,
  output logic                instr_done,
  output logic                illegal_op,
  output logic                fault
`ifdef MCTRL_PERF_EN
  ,
  output logic [31:0]         retired_cnt,
  output logic [31:0]         stall_cnt
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(3'b000);
  localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(3'b010);
  localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(3'b110);

  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(7);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  state_t              state, state_next;
  logic [OPCODE_W-1:0] op_q;
  logic [CNT_W-1:0]    tmo_cnt;
  logic                tmo_hit;
  logic                req, wr;

  assign mem.mem_req  = req;
  assign mem.memwrite = wr;
  assign tmo_hit      = (tmo_cnt == CNT_W'(TIMEOUT)) && !mem.mem_ack;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)                                      tmo_cnt <= '0;
    else if ((state_next != state) || mem.mem_ack)     tmo_cnt <= '0;
    else if (req)                                      tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (state == S_DECODE) op_q <= opcode;
  end

  // Everything is held low while reset_n is asserted, whatever the state register holds.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    wr         = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alusrc     = 1'b0;
    alucontrol = ALU_AND;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    fault      = 1'b0;
    if (reset_n) begin
      case (state)
        S_FETCH: begin
          if (run) begin
            req = 1'b1;
            if (mem.mem_ack) begin
              ir_write   = 1'b1;
              pc_write   = 1'b1;
              state_next = S_DECODE;
            end else if (tmo_hit) begin
              state_next = S_FAULT;
            end
          end
        end
        S_DECODE: begin
          if (opcode > OP_J) begin
            illegal_op = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          case (op_q)
            OP_ADD:  begin alucontrol = ALU_ADD; state_next = S_WB; end
            OP_ADDI: begin alucontrol = ALU_ADD; alusrc = 1'b1; state_next = S_WB; end
            OP_SUB:  begin alucontrol = ALU_SUB; state_next = S_WB; end
            OP_AND:  begin alucontrol = ALU_AND; state_next = S_WB; end
            OP_LW, OP_SW: begin
              alucontrol = ALU_ADD;
              alusrc     = 1'b1;
              state_next = S_MEM;
            end
            OP_BNE: begin
              alucontrol = ALU_SUB;
              pc_src     = 1'b1;
              pc_write   = ~zero;
              instr_done = 1'b1;
              state_next = S_FETCH;
            end
            OP_J: begin
              pc_src     = 1'b1;
              pc_write   = 1'b1;
              instr_done = 1'b1;
              state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
          endcase
        end
        S_MEM: begin
          req        = 1'b1;
          alusrc     = 1'b1;
          alucontrol = ALU_ADD;
          wr         = (op_q == OP_SW);
          if (mem.mem_ack) begin
            if (op_q == OP_SW) begin
              instr_done = 1'b1;
              state_next = S_FETCH;
            end else begin
              state_next = S_WB;
            end
          end else if (tmo_hit) begin
            state_next = S_FAULT;
          end
        end
        S_WB: begin
          regwrite   = 1'b1;
          memtoreg   = (op_q == OP_LW);
          instr_done = 1'b1;
          state_next = S_FETCH;
        end
        S_FAULT: begin
          fault      = 1'b1;
          state_next = S_FAULT;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

`ifdef MCTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (instr_done)           retired_cnt <= retired_cnt + 32'd1;
      if (req && !mem.mem_ack)  stall_cnt   <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Cycle-accurate bench for multicycle_control: per-cycle expected output vectors are
// queued for each scenario and popped as the design steps through its states.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       run;
  logic [3:0] opcode;
  logic       zero;
  logic       ack;
  logic       ir_write, pc_write, pc_src, alusrc, memtoreg, regwrite;
  logic       instr_done, illegal_op, fault;
  logic [2:0] alucontrol;
`ifdef MCTRL_PERF_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  int nvec = 0;
  int nerr = 0;

  multicycle_control_if mif ();
  assign mif.mem_ack = ack;

  multicycle_control #(.OPCODE_W(4), .ALUCTL_W(3), .TIMEOUT(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .opcode     (opcode),
    .zero       (zero),
    .mem        (mif.master),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alusrc     (alusrc),
    .alucontrol (alucontrol),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .fault      (fault)
`ifdef MCTRL_PERF_EN
    ,
    .retired_cnt(retired_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // {mem_req, memwrite, ir_write, pc_write, pc_src, alusrc, alucontrol[2:0],
  //  memtoreg, regwrite, instr_done, illegal_op, fault}
  logic [13:0] outv;
  assign outv = {mif.mem_req, mif.memwrite, ir_write, pc_write, pc_src, alusrc,
                 alucontrol, memtoreg, regwrite, instr_done, illegal_op, fault};

  localparam logic [13:0] IDLE  = 14'h0000;
  localparam logic [13:0] REQ   = 14'h2000;
  localparam logic [13:0] WR    = 14'h1000;
  localparam logic [13:0] IRW   = 14'h0800;
  localparam logic [13:0] PCW   = 14'h0400;
  localparam logic [13:0] PCS   = 14'h0200;
  localparam logic [13:0] ASRC  = 14'h0100;
  localparam logic [13:0] A_ADD = 14'h0040;
  localparam logic [13:0] A_SUB = 14'h00C0;
  localparam logic [13:0] M2R   = 14'h0010;
  localparam logic [13:0] RW    = 14'h0008;
  localparam logic [13:0] DONE  = 14'h0004;
  localparam logic [13:0] ILL   = 14'h0002;
  localparam logic [13:0] FLT   = 14'h0001;
  localparam logic [13:0] FOK   = REQ | IRW | PCW;
  localparam logic [13:0] MEMLD = REQ | ASRC | A_ADD;
  localparam logic [13:0] MEMST = REQ | WR | ASRC | A_ADD;

  logic [13:0] expq[$];
  bit          ackq[$];
  bit          runq[$];
  logic [3:0]  opq[$];
  logic [13:0] exp_v;

  // Tasks are entered and left just after a falling edge.
  task automatic do_reset();
    reset_n = 1'b0;
    run     = 1'b0;
    ack     = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    int c = 0;
    reset_n = 1'b0; run = 1'b1; ack = 1'b1; opcode = 4'd0; zero = 1'b0;
    expq = '{IDLE, IDLE};
    while (expq.size() > 0) begin
      #1; exp_v = expq.pop_front(); nvec++;
      if (outv !== exp_v) begin
        nerr++; $display("FAIL reset cyc%0d: got %h want %h", c, outv, exp_v);
      end
      c++; @(negedge clk);
    end
    reset_n = 1'b1; #1; nvec++;
    if (outv !== FOK) begin
      nerr++; $display("FAIL reset_release: got %h want %h", outv, FOK);
    end
    @(negedge clk);
  endtask

  task automatic test_alu_ops();
    logic [13:0] ex;
    for (int op = 0; op < 4; op++) begin
      do_reset();
      run = 1'b1; ack = 1'b1; zero = 1'b0; opcode = 4'(op);
      case (op)
        0:       ex = A_ADD;
        1:       ex = A_ADD | ASRC;
        2:       ex = A_SUB;
        default: ex = IDLE;
      endcase
      expq = '{FOK, IDLE, ex, RW | DONE, FOK};
      for (int c = 0; expq.size() > 0; c++) begin
        #1; exp_v = expq.pop_front(); nvec++;
        if (outv !== exp_v) begin
          nerr++; $display("FAIL alu_op%0d cyc%0d: got %h want %h", op, c, outv, exp_v);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_lw();
    do_reset();
    run = 1'b1; zero = 1'b0; opcode = 4'd4;
    expq = '{FOK, IDLE, A_ADD | ASRC, MEMLD, MEMLD, MEMLD, RW | M2R | DONE, FOK};
    ackq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int c = 0; expq.size() > 0; c++) begin
      ack = ackq.pop_front(); #1; exp_v = expq.pop_front(); nvec++;
      if (outv !== exp_v) begin
        nerr++; $display("FAIL lw cyc%0d: got %h want %h", c, outv, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw();
    do_reset();
    run = 1'b1; zero = 1'b0; opcode = 4'd5;
    expq = '{FOK, IDLE, A_ADD | ASRC, MEMST, MEMST | DONE, FOK};
    ackq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int c = 0; expq.size() > 0; c++) begin
      ack = ackq.pop_front(); #1; exp_v = expq.pop_front(); nvec++;
      if (outv !== exp_v) begin
        nerr++; $display("FAIL sw cyc%0d: got %h want %h", c, outv, exp_v);
      end
      @(negedge clk);
    end
    // Reset lands while the store is still waiting for the memory.
    do_reset();
    run = 1'b1; opcode = 4'd5;
    expq = '{FOK, IDLE, A_ADD | ASRC, MEMST};
    ackq = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; expq.size() > 0; c++) begin
      ack = ackq.pop_front(); #1; exp_v = expq.pop_front(); nvec++;
      if (outv !== exp_v) begin
        nerr++; $display("FAIL sw_abort cyc%0d: got %h want %h", c, outv, exp_v);
      end
      @(negedge clk);
    end
    reset_n = 1'b0; ack = 1'b1; #1; nvec++;
    if (outv !== IDLE) begin
      nerr++; $display("FAIL sw_abort_in_reset: got %h want %h", outv, IDLE);
    end
    @(negedge clk);
    reset_n = 1'b1; #1; nvec++;
    if (outv !== FOK) begin
      nerr++; $display("FAIL sw_abort_refetch: got %h want %h", outv, FOK);
    end
    @(negedge clk);
  endtask

  task automatic test_branch();
    logic [3:0]  ops[4] = '{4'd6, 4'd6, 4'd7, 4'd7};
    bit          zs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [13:0] exs[4] = '{A_SUB | PCS | PCW | DONE, A_SUB | PCS | DONE,
                            PCS | PCW | DONE, PCS | PCW | DONE};
    for (int k = 0; k < 4; k++) begin
      do_reset();
      run = 1'b1; ack = 1'b1; opcode = ops[k]; zero = zs[k];
      expq = '{FOK, IDLE, exs[k], FOK};
      for (int c = 0; expq.size() > 0; c++) begin
        #1; exp_v = expq.pop_front(); nvec++;
        if (outv !== exp_v) begin
          nerr++; $display("FAIL branch op%0d z%0d cyc%0d: got %h want %h",
                           ops[k], zs[k], c, outv, exp_v);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_illegal();
    logic [3:0] bad[2] = '{4'd9, 4'd15};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      run = 1'b1; ack = 1'b1; zero = 1'b0; opcode = bad[k];
      expq = '{FOK, ILL, FOK, ILL};
      for (int c = 0; expq.size() > 0; c++) begin
        #1; exp_v = expq.pop_front(); nvec++;
        if (outv !== exp_v) begin
          nerr++; $display("FAIL illegal op%0d cyc%0d: got %h want %h", bad[k], c, outv, exp_v);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_fetch_stall();
    do_reset();
    zero = 1'b0; opcode = 4'd0;
    expq = '{IDLE, IDLE, REQ, REQ, FOK, IDLE};
    runq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    ackq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int c = 0; expq.size() > 0; c++) begin
      run = runq.pop_front(); ack = ackq.pop_front();
      #1; exp_v = expq.pop_front(); nvec++;
      if (outv !== exp_v) begin
        nerr++; $display("FAIL fetch_stall cyc%0d: got %h want %h", c, outv, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    run = 1'b1; zero = 1'b0; opcode = 4'd0;
    expq = '{REQ, REQ, REQ, REQ, REQ, FLT, FLT, FLT};
    ackq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int c = 0; expq.size() > 0; c++) begin
      ack = ackq.pop_front(); #1; exp_v = expq.pop_front(); nvec++;
      if (outv !== exp_v) begin
        nerr++; $display("FAIL timeout_fetch cyc%0d: got %h want %h", c, outv, exp_v);
      end
      @(negedge clk);
    end
    reset_n = 1'b0; ack = 1'b1; #1; nvec++;
    if (outv !== IDLE) begin
      nerr++; $display("FAIL timeout_in_reset: got %h want %h", outv, IDLE);
    end
    @(negedge clk);
    reset_n = 1'b1; #1; nvec++;
    if (outv !== FOK) begin
      nerr++; $display("FAIL timeout_recover: got %h want %h", outv, FOK);
    end
    @(negedge clk);
    // Timeout while a load waits in MEM.
    do_reset();
    run = 1'b1; opcode = 4'd4;
    expq = '{FOK, IDLE, A_ADD | ASRC, MEMLD, MEMLD, MEMLD, MEMLD, MEMLD, FLT};
    ackq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int c = 0; expq.size() > 0; c++) begin
      ack = ackq.pop_front(); #1; exp_v = expq.pop_front(); nvec++;
      if (outv !== exp_v) begin
        nerr++; $display("FAIL timeout_mem cyc%0d: got %h want %h", c, outv, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run = 1'b1; ack = 1'b1; zero = 1'b1;
    expq = '{FOK, IDLE, A_ADD, RW | DONE, FOK, IDLE, PCS | PCW | DONE, FOK};
    opq  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 4'd7, 4'd7, 4'd7};
    for (int c = 0; expq.size() > 0; c++) begin
      opcode = opq.pop_front(); #1; exp_v = expq.pop_front(); nvec++;
      if (outv !== exp_v) begin
        nerr++; $display("FAIL back_to_back cyc%0d: got %h want %h", c, outv, exp_v);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; ack = 1'b0; zero = 1'b0; opcode = 4'd0;
    @(negedge clk);
    test_reset();
    test_alu_ops();
    test_lw();
    test_sw();
    test_branch();
    test_illegal();
    test_fetch_stall();
    test_timeout();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
